// File: rtl/reg_bank_reader_if.sv
// Consumer-side handshake bundle for reg_bank_reader.
// DataParity exists only when REG_BANK_READER_PARITY_EN is defined.
interface reg_bank_reader_if #(
    parameter int NrOfBits = 8,
    parameter int AddrBits = 2
);
    logic [NrOfBits-1:0] DataOut;
    logic [AddrBits-1:0] DataAddr;
    logic                DataValid;
    logic                DataReady;
`ifdef REG_BANK_READER_PARITY_EN
    logic                DataParity;
`endif

    modport master (
        input  DataReady,
        output DataOut,
        output DataAddr,
        output DataValid
`ifdef REG_BANK_READER_PARITY_EN
        , output DataParity
`endif
    );

    modport slave (
        output DataReady,
        input  DataOut,
        input  DataAddr,
        input  DataValid
`ifdef REG_BANK_READER_PARITY_EN
        , input  DataParity
`endif
    );
endinterface

// File: rtl/reg_bank_reader.sv
// Walks a run of tri-state bus registers, capturing one word per select.
// Define REG_BANK_READER_PARITY_EN to add a registered DataParity bit.
module reg_bank_reader #(
    parameter int NrOfBits     = 8,
    parameter int NrOfRegs     = 4,
    parameter int AddrBits     = 2,
    parameter int SettleCycles = 1
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                ClockEnable,
    input  logic                Tick,
    input  logic                Start,
    input  logic [AddrBits-1:0] StartAddr,
    input  logic [AddrBits:0]   Count,
    input  logic [NrOfBits-1:0] BusIn,
    output logic [NrOfRegs-1:0] cs,
    output logic                Busy,
    output logic                Done,
    reg_bank_reader_if.master   dbus
);
    localparam int CntW = AddrBits + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CAPTURE,
        S_HOLD,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [AddrBits-1:0] addr_q, addr_d;
    logic [CntW-1:0]     remain_q, remain_d;
    logic [3:0]          settle_q, settle_d;
    logic [NrOfBits-1:0] data_q, data_d;
    logic [AddrBits-1:0] daddr_q, daddr_d;
    logic                valid_q, valid_d;
`ifdef REG_BANK_READER_PARITY_EN
    logic                par_q, par_d;
`endif
    logic                en;

    assign en = ClockEnable & Tick;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            settle_q <= '0;
            data_q   <= '0;
            daddr_q  <= '0;
            valid_q  <= 1'b0;
`ifdef REG_BANK_READER_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else if (en) begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            settle_q <= settle_d;
            data_q   <= data_d;
            daddr_q  <= daddr_d;
            valid_q  <= valid_d;
`ifdef REG_BANK_READER_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        settle_d = settle_q;
        data_d   = data_q;
        daddr_d  = daddr_q;
        valid_d  = valid_q;
`ifdef REG_BANK_READER_PARITY_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    addr_d   = StartAddr;
                    remain_d = (Count == '0) ? CntW'(NrOfRegs) : Count;
                    settle_d = 4'(SettleCycles - 1);
                    state_d  = S_SELECT;
                end
            end
            // settle_q holds the ticks still owed after the current one
            S_SELECT: begin
                if (settle_q == 4'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_CAPTURE: begin
                data_d  = BusIn;
                daddr_d = addr_q;
                valid_d = 1'b1;
`ifdef REG_BANK_READER_PARITY_EN
                par_d   = ^BusIn;
`endif
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (dbus.DataReady) begin
                    valid_d  = 1'b0;
                    remain_d = remain_q - CntW'(1);
                    settle_d = 4'(SettleCycles - 1);
                    if (addr_q == AddrBits'(NrOfRegs - 1)) begin
                        addr_d = '0;
                    end else begin
                        addr_d = addr_q + AddrBits'(1);
                    end
                    if (remain_q == CntW'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SELECT;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Only SELECT and CAPTURE drive a register onto the bus
    always_comb begin
        cs = '1;
        if (state_q == S_SELECT || state_q == S_CAPTURE) begin
            cs[addr_q] = 1'b0;
        end
    end

    assign Busy           = (state_q != S_IDLE);
    assign Done           = (state_q == S_DONE);
    assign dbus.DataOut   = data_q;
    assign dbus.DataAddr  = daddr_q;
    assign dbus.DataValid = valid_q;
`ifdef REG_BANK_READER_PARITY_EN
    assign dbus.DataParity = par_q;
`endif
endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed bench for reg_bank_reader; bus model returns 0xA0 + address.
// Parity checks run when REG_BANK_READER_PARITY_EN is defined.
module tb_reg_bank_reader;
    logic       Clock       = 1'b0;
    logic       Reset_n     = 1'b0;
    logic       ClockEnable = 1'b0;
    logic       Tick        = 1'b0;
    logic       Start       = 1'b0;
    logic [1:0] StartAddr   = 2'd0;
    logic [2:0] Count       = 3'd0;
    logic [7:0] BusIn;
    logic [3:0] cs;
    logic       Busy;
    logic       Done;

    reg_bank_reader_if #(.NrOfBits(8), .AddrBits(2)) dbus ();

    reg_bank_reader #(
        .NrOfBits(8),
        .NrOfRegs(4),
        .AddrBits(2),
        .SettleCycles(1)
    ) dut (
        .Clock(Clock),
        .Reset_n(Reset_n),
        .ClockEnable(ClockEnable),
        .Tick(Tick),
        .Start(Start),
        .StartAddr(StartAddr),
        .Count(Count),
        .BusIn(BusIn),
        .cs(cs),
        .Busy(Busy),
        .Done(Done),
        .dbus(dbus)
    );

    always #5 Clock = ~Clock;

    logic       ovr_en  = 1'b0;
    logic [7:0] ovr_val = 8'h00;

    always_comb begin
        BusIn = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            if (!cs[i]) BusIn = ovr_en ? ovr_val : 8'(8'hA0 + i);
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int cs_bad = 0;

    always @(negedge Clock) begin
        if (Reset_n && $countones(~cs) > 1) cs_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    logic [7:0] words[$];
    logic [1:0] addrs[$];
    logic [3:0] css[$];
    int         clocks;
    int         done_clks;

    task automatic do_run(input logic [1:0] sa, input logic [2:0] cnt,
                          input int gate);
        logic [3:0] pcs;
        logic       pv;
        words.delete();
        addrs.delete();
        css.delete();
        done_clks      = 0;
        ClockEnable    = 1'b1;
        dbus.DataReady = 1'b1;
        StartAddr      = sa;
        Count          = cnt;
        Start          = 1'b1;
        Tick           = 1'b1;
        step();
        Start  = 1'b0;
        clocks = 1;
        pcs    = 4'hF;
        pv     = 1'b0;
        for (int k = 1; k < 400; k++) begin
            if (!Busy) break;
            if (cs != 4'hF && cs != pcs) css.push_back(cs);
            if (dbus.DataValid && !pv) begin
                words.push_back(dbus.DataOut);
                addrs.push_back(dbus.DataAddr);
            end
            if (Done) done_clks++;
            pcs  = cs;
            pv   = dbus.DataValid;
            Tick = (k % gate == 0);
            step();
            clocks++;
        end
        Tick = 1'b1;
        chk("run_end_busy", Busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        dbus.DataReady = 1'b1;
        repeat (2) step();
        chk("rst_cs", cs, 4'hF);
        chk("rst_busy", Busy, 0);
        chk("rst_valid", dbus.DataValid, 0);
        chk("rst_done", Done, 0);
        chk("rst_data", dbus.DataOut, 0);
        chk("rst_addr", dbus.DataAddr, 0);
        Reset_n     = 1'b1;
        ClockEnable = 1'b1;
        Tick        = 1'b1;
        step();
        chk("idle_busy", Busy, 0);

        do_run(2'd1, 3'd2, 1);
        chk("basic_n", words.size(), 2);
        chk("basic_w0", words[0], 8'hA1);
        chk("basic_a0", addrs[0], 1);
        chk("basic_w1", words[1], 8'hA2);
        chk("basic_a1", addrs[1], 2);
        chk("basic_ncs", css.size(), 2);
        chk("basic_cs0", css[0], 4'b1101);
        chk("basic_cs1", css[1], 4'b1011);
        chk("basic_ticks", clocks, 8);
        chk("basic_done", done_clks, 1);

        do_run(2'd3, 3'd0, 1);
        chk("wrap_n", words.size(), 4);
        chk("wrap_a0", addrs[0], 3);
        chk("wrap_a1", addrs[1], 0);
        chk("wrap_a2", addrs[2], 1);
        chk("wrap_a3", addrs[3], 2);
        chk("wrap_w0", words[0], 8'hA3);
        chk("wrap_w1", words[1], 8'hA0);
        chk("wrap_w3", words[3], 8'hA2);
        chk("wrap_ticks", clocks, 14);

        do_run(2'd1, 3'd2, 3);
        chk("gate_n", words.size(), 2);
        chk("gate_w0", words[0], 8'hA1);
        chk("gate_a0", addrs[0], 1);
        chk("gate_w1", words[1], 8'hA2);
        chk("gate_a1", addrs[1], 2);
        chk("gate_clocks", clocks, 22);
        chk("gate_done", done_clks, 3);

        StartAddr = 2'd2;
        Count     = 3'd1;
        Start     = 1'b1;
        step();
        Start          = 1'b0;
        dbus.DataReady = 1'b0;
        step();
        step();
        chk("bp_valid", dbus.DataValid, 1);
        chk("bp_data", dbus.DataOut, 8'hA2);
        chk("bp_addr", dbus.DataAddr, 2);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", dbus.DataValid, 1);
            chk("bp_hold_data", dbus.DataOut, 8'hA2);
            chk("bp_hold_addr", dbus.DataAddr, 2);
            chk("bp_hold_cs", cs, 4'hF);
        end
        dbus.DataReady = 1'b1;
        step();
        chk("bp_done", Done, 1);
        chk("bp_valid_clr", dbus.DataValid, 0);
        step();
        chk("bp_idle", Busy, 0);

        StartAddr = 2'd0;
        Count     = 3'd1;
        Start     = 1'b1;
        step();
        Start = 1'b0;
        chk("frz_cs", cs, 4'b1110);
        ClockEnable = 1'b0;
        repeat (5) step();
        chk("frz_cs_hold", cs, 4'b1110);
        chk("frz_busy", Busy, 1);
        chk("frz_valid", dbus.DataValid, 0);
        ClockEnable = 1'b1;
        step();
        step();
        chk("frz_resume_v", dbus.DataValid, 1);
        chk("frz_resume_d", dbus.DataOut, 8'hA0);
        step();
        step();
        chk("frz_idle", Busy, 0);

        StartAddr = 2'd1;
        Count     = 3'd2;
        Start     = 1'b1;
        step();
        Start = 1'b0;
        chk("mrst_pre_cs", cs, 4'b1101);
        #1 Reset_n = 1'b0;
        #1;
        chk("mrst_cs", cs, 4'hF);
        chk("mrst_busy", Busy, 0);
        chk("mrst_valid", dbus.DataValid, 0);
        chk("mrst_done", Done, 0);
        step();
        Reset_n   = 1'b1;
        StartAddr = 2'd3;
        Count     = 3'd1;
        Start     = 1'b1;
        step();
        Start = 1'b0;
        chk("mrst_restart_cs", cs, 4'b0111);
        step();
        step();
        chk("mrst_data", dbus.DataOut, 8'hA3);
        step();
        step();
        chk("mrst_idle", Busy, 0);

`ifdef REG_BANK_READER_PARITY_EN
        ovr_en    = 1'b1;
        ovr_val   = 8'h07;
        StartAddr = 2'd0;
        Count     = 3'd1;
        Start     = 1'b1;
        step();
        Start = 1'b0;
        step();
        step();
        chk("par_07", dbus.DataParity, 1);
        step();
        step();
        ovr_val = 8'h03;
        Start   = 1'b1;
        step();
        Start = 1'b0;
        step();
        step();
        chk("par_03", dbus.DataParity, 0);
        step();
        step();
        ovr_en = 1'b0;
`endif

        chk("cs_onehot", cs_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
